// File: rtl/wave_synth.sv
// Sample-rate waveform synthesiser: phase accumulator, shape, gain, LFSR noise
// and saturation, producing one 8-bit unsigned sample every SAMPLE_DIV clocks.
module wave_synth #(
    parameter int unsigned SAMPLE_DIV = 50,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] amp_factor,
    input  logic [3:0] freq_factor,
    input  logic [4:0] noise_amp_factor,
    input  logic [1:0] wave_sel,
    input  logic       noise_en,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       phase_wrap
);
    localparam int unsigned   CW      = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    // Stage 0: phase, LFSR and a snapshot of the controls for this sample
    logic [15:0] phase_q, lfsr_q, lfsr_d;
    logic        wrap0_q, v0_q;
    logic [3:0]  amp0_q;
    logic [4:0]  namp0_q;
    logic [1:0]  sel0_q;
    logic        nen0_q;
    logic [4:0]  freq_inc;
    logic [16:0] phase_sum;

    // Stage 1: shape and gain
    logic [7:0]         p, u, s8;
    logic signed [12:0] amp_prod, amp_shr, noise_prod, noise_shr;
    logic [8:0]         a_d, a1_q;
    logic [7:0]         nz_d, nz1_q;
    logic               wrap1_q, v1_q;

    // Stage 2: sum and saturate
    logic signed [10:0] sum_d;
    logic [7:0]         sat_d, sample_q;
    logic               sample_valid_q, phase_wrap_q;

    assign tick      = (cnt_q == CNT_MAX);
    assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
    assign freq_inc  = {1'b0, freq_factor} + 5'd1;
    assign phase_sum = {1'b0, phase_q} + {6'b0, freq_inc, 6'b0};
    assign lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= '0;
            lfsr_q  <= LFSR_SEED;
            wrap0_q <= 1'b0;
            v0_q    <= 1'b0;
            amp0_q  <= '0;
            namp0_q <= '0;
            sel0_q  <= '0;
            nen0_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            v0_q  <= tick;
            if (tick) begin
                phase_q <= phase_sum[15:0];
                wrap0_q <= phase_sum[16];
                lfsr_q  <= lfsr_d;
                amp0_q  <= amp_factor;
                namp0_q <= noise_amp_factor;
                sel0_q  <= wave_sel;
                nen0_q  <= noise_en;
            end
        end
    end

    always_comb begin
        p = phase_q[15:8];
        u = 8'd128;
        case (sel0_q)
            2'b00:   u = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            2'b01:   u = p[7] ? 8'd0 : 8'd255;
            2'b10:   u = p;
            default: u = 8'd128;
        endcase
    end

    // u - 128 in two's complement is u with the msb inverted
    assign s8         = {~u[7], u[6:0]};
    assign amp_prod   = $signed({{5{s8[7]}}, s8}) * $signed({9'b0, amp0_q});
    assign amp_shr    = amp_prod >>> 3;
    assign noise_prod = $signed({{5{lfsr_q[7]}}, lfsr_q[7:0]}) * $signed({8'b0, namp0_q});
    assign noise_shr  = noise_prod >>> 5;
    assign a_d        = amp_shr[8:0];
    assign nz_d       = nen0_q ? noise_shr[7:0] : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q    <= '0;
            nz1_q   <= '0;
            wrap1_q <= 1'b0;
            v1_q    <= 1'b0;
        end else begin
            v1_q <= v0_q;
            if (v0_q) begin
                a1_q    <= a_d;
                nz1_q   <= nz_d;
                wrap1_q <= wrap0_q;
            end
        end
    end

    assign sum_d = $signed({{2{a1_q[8]}}, a1_q}) + $signed({{3{nz1_q[7]}}, nz1_q}) + 11'sd128;

    always_comb begin
        sat_d = sum_d[7:0];
        if (sum_d[10]) begin
            sat_d = 8'd0;
        end else if (sum_d[9:8] != 2'b00) begin
            sat_d = 8'd255;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q       <= 8'd128;
            sample_valid_q <= 1'b0;
            phase_wrap_q   <= 1'b0;
        end else begin
            sample_valid_q <= v1_q;
            phase_wrap_q   <= v1_q & wrap1_q;
            if (v1_q) begin
                sample_q <= sat_d;
            end
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign phase_wrap   = phase_wrap_q;
endmodule

// File: tb/tb_wave_synth.sv
// Directed bench for wave_synth: latency/strobe timing, each waveform shape,
// gain saturation, LFSR noise and reset mid-stream.
module tb_wave_synth;
    localparam int DIV = 5;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [1:0] TRI = 2'b00, SQR = 2'b01, SAW = 2'b10, DC = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] amp_factor, freq_factor;
    logic [4:0] noise_amp_factor;
    logic [1:0] wave_sel;
    logic       noise_en;
    logic [7:0] sample;
    logic       sample_valid, phase_wrap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wave_synth #(.SAMPLE_DIV(DIV), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n),
        .amp_factor(amp_factor), .freq_factor(freq_factor),
        .noise_amp_factor(noise_amp_factor), .wave_sel(wave_sel),
        .noise_en(noise_en), .sample(sample),
        .sample_valid(sample_valid), .phase_wrap(phase_wrap)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Returns at the negedge where the next strobe is seen
    task automatic wait_sample(output int val, output int wrap);
        int n;
        n = 0;
        @(negedge clk);
        while (!sample_valid && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (!sample_valid) check("strobe_timeout", 0, 1);
        val  = int'(sample);
        wrap = int'(phase_wrap);
        $display("sample t=%0t val=%0d wrap=%0d", $time, val, wrap);
    endtask

    task automatic count_to_valid(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (sample_valid) break;
        end
    endtask

    task automatic do_reset(input logic [1:0] sel, input int amp, input int freq,
                            input int namp, input logic nen);
        rst_n            = 1'b0;
        wave_sel         = sel;
        amp_factor       = 4'(amp);
        freq_factor      = 4'(freq);
        noise_amp_factor = 5'(namp);
        noise_en         = nen;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic int noise_of(input logic [15:0] l, input int namp);
        int n;
        n = int'($signed(l[7:0]));
        return (n * namp) >>> 5;
    endfunction

    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    initial begin
        int v, w, n, exp_v;
        int amps[3];
        int his[3];
        int los[3];
        logic [15:0] l;

        // Reset state and strobe timing, saw amp 8 freq 0
        rst_n = 1'b0;
        wave_sel = SAW; amp_factor = 4'd8; freq_factor = 4'd0;
        noise_amp_factor = 5'd0; noise_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sample", sample, 128);
        check("rst_valid", sample_valid, 0);
        check("rst_wrap", phase_wrap, 0);
        rst_n = 1'b1;
        check("rel_sample", sample, 128);
        count_to_valid(n);
        check("first_latency", n, DIV + 2);
        check("saw_k1", sample, 0);
        @(negedge clk);
        check("strobe_width", sample_valid, 0);
        n = 0;
        while (!sample_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("strobe_gap", n, DIV - 1);
        check("saw_k2", sample, 0);

        for (int k = 3; k <= 2048; k++) begin
            wait_sample(v, w);
            check("saw_val", v, ((64 * k) % 65536) / 256);
            check("saw_wrap", w, (k % 1024 == 0) ? 1 : 0);
        end

        // Square: saturated at amp 15, mute at amp 0, 191/64 at amp 4
        amps = '{15, 0, 4};
        his  = '{255, 128, 191};
        los  = '{0, 128, 64};
        for (int i = 0; i < 3; i++) begin
            do_reset(SQR, amps[i], 0, 0, 1'b0);
            for (int k = 1; k <= 1100; k++) begin
                wait_sample(v, w);
                check("sqr_val", v, ((k % 1024) < 512) ? his[i] : los[i]);
                check("sqr_wrap", w, (k % 1024 == 0) ? 1 : 0);
            end
        end

        // Triangle, step 1024: rises 8 per sample for 32 samples, then falls
        do_reset(TRI, 8, 15, 0, 1'b0);
        for (int k = 1; k <= 130; k++) begin
            wait_sample(v, w);
            exp_v = ((k % 64) < 32) ? 8 * (k % 64) : 255 - 8 * ((k % 64) - 32);
            check("tri_val", v, exp_v);
            check("tri_wrap", w, (k % 64 == 0) ? 1 : 0);
        end

        // DC with full noise against an LFSR model
        do_reset(DC, 8, 0, 31, 1'b1);
        l = SEED;
        for (int k = 1; k <= 200; k++) begin
            l = lfsr_step(l);
            wait_sample(v, w);
            check("dc_noise", v, 128 + noise_of(l, 31));
        end
        do_reset(DC, 8, 0, 0, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            wait_sample(v, w);
            check("dc_namp0", v, 128);
        end
        do_reset(DC, 8, 0, 31, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            wait_sample(v, w);
            check("dc_noise_off", v, 128);
        end

        // Mid-stream amp change and reset one cycle after a tick
        do_reset(SAW, 8, 15, 0, 1'b0);
        wait_sample(v, w);
        check("chg_k1", v, 4);
        wait_sample(v, w);
        check("chg_k2", v, 8);
        repeat (3) @(negedge clk);
        amp_factor = 4'd15;
        wait_sample(v, w);
        check("chg_k3_old_amp", v, 12);
        wait_sample(v, w);
        check("chg_k4_new_amp", v, sat((((16 - 128) * 15) >>> 3) + 128));
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_sample", sample, 128);
        check("mid_rst_valid", sample_valid, 0);
        amp_factor = 4'd8; noise_en = 1'b1; noise_amp_factor = 5'd31;
        rst_n = 1'b1;
        count_to_valid(n);
        check("post_rst_latency", n, DIV + 2);
        l = lfsr_step(SEED);
        check("post_rst_k1", sample, sat(4 + noise_of(l, 31)));
        for (int k = 2; k <= 6; k++) begin
            l = lfsr_step(l);
            wait_sample(v, w);
            check("post_rst_val", v, sat(4 * k + noise_of(l, 31)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
